fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage; producer side of the decode interface.
//  - Holds the PC and issues word fetches to instruction memory.
//  - Presents each instruction word, its PC and PC+4 to the decode/control path over a valid/ready handshake.
//  - Takes branch/jump redirects back from execute.
// PARAMETERS
//  ADDR_WIDTH  32            PC / imem address width
//  DATA_WIDTH  32            instruction word width
//  RESET_PC    32'h0000_0000 first fetch address after reset
// PORTS
//  clk             in   1           clock, all state on posedge
//  rst             in   1           reset, synchronous, active-high
//  imem_req        out  1           fetch request
//  imem_addr       out  ADDR_WIDTH  fetch address, word aligned
//  imem_ack        in   1           rdata valid, this request done
//  imem_rdata      in   DATA_WIDTH  fetched word
//  redirect        in   1           1-cycle pulse: taken branch/jump
//  redirect_target in   ADDR_WIDTH  new PC when redirect=1
//  instr_valid     out  1           instr/instr_pc valid to decode
//  instr_ready     in   1           decode accepts this cycle
//  instr           out  DATA_WIDTH  instruction word
//  instr_pc        out  ADDR_WIDTH  PC of instr
//  instr_pc_plus4  out  ADDR_WIDTH  instr_pc + 4, mod 2^ADDR_WIDTH
//  fetch_misaligned out 1           sticky misaligned-target flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - state=FETCH, pc=RESET_PC.
//    - instr_valid=0; instr, instr_pc, instr_pc_plus4=0; fetch_misaligned=0.
//    - imem_req forced 0 while rst=1.
//    - rst mid-transaction aborts it; a late imem_ack after reset is ignored if it arrives while rst=1.
//  - States: FETCH, HOLD, DROP, HALT.
//  - imem_req=1 in FETCH and DROP; imem_addr = pc (FETCH) or in-flight addr (DROP).
//    - Request is held with stable addr until imem_ack; never withdrawn early.
//    - imem_ack ignored when imem_req=0.
//  - FETCH:
//    - imem_ack=1, no redirect: capture rdata, instr_pc=pc, instr_pc_plus4=pc+4, instr_valid=1 next cycle, pc<=pc+4, ->HOLD.
//    - Min latency: ack at cycle N -> instr_valid at N+1.
//  - HOLD:
//    - instr_valid=1; instr/instr_pc stay stable until instr_ready=1.
//    - On handshake ->FETCH, instr_valid=0 next cycle.
//    - Throughput: 1 instr per 2 cycles at zero-wait memory.
//  - Redirect (highest priority), PC<=redirect_target (bits[1:0] see CONFIGURATION):
//    - FETCH, ack same cycle: data discarded, stay FETCH at target next cycle.
//    - FETCH, no ack: ->DROP; target saved; next ack discarded, then ->FETCH at target.
//    - DROP, further redirect: saved target overwritten (latest wins).
//    - HOLD: instr_valid<=0 next cycle, ->FETCH at target.
//      - redirect+instr_ready same cycle: handshake counts as completed, then redirect applies.
//  - pc increments wrap at 2^ADDR_WIDTH silently.
// CONFIGURATION
//  - Macro FETCH_MISALIGN_TRAP_EN:
//    - Defined: redirect with target[1:0]!=0 sets fetch_misaligned=1 (sticky until rst) and ->HALT.
//      - HALT: imem_req=0, instr_valid=0, redirects ignored, exit only via rst.
//      - If a request is in flight, go via DROP (discard ack), then HALT.
//    - Undefined: target[1:0] forced to 2'b00; fetch_misaligned tied 0; HALT unreachable.
// TESTING
//  1. Reset RESET_PC=0, ack after 1 cycle, ready=1 -> instrs at pc 0,4,8; pc_plus4 4,8,12; valid 0 during rst.
//  2. Hold ready=0 for 5 cycles with instr=32'h00500093 -> instr/instr_pc stable, imem_req=0 until ready.
//  3. Redirect to 0x100 while req pending (ack 3 cycles later, rdata=DEADBEEF)
//     -> DEADBEEF never valid; next imem_addr=0x100.
//  4. Redirect 0x40 then 0x80 in DROP -> only 0x80 fetched; redirect+ready same cycle in HOLD -> no duplicate instr.
//  5. pc=0xFFFF_FFFC fetch -> instr_pc_plus4=0, next imem_addr=0.
//  6. Redirect target 0x102: with FETCH_MISALIGN_TRAP_EN, flag=1, req=0 until rst;
//     without, fetch at 0x100, flag=0.

Source files
------------

// File: rtl/fetch_if.sv
// Decode-side and imem-side signal bundle of the fetch stage.
// master = fetch_unit, slave = memory / execute / decode environment.
interface fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic [ADDR_WIDTH-1:0] instr_pc_plus4;
    logic                  fetch_misaligned;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4, fetch_misaligned,
        input  imem_ack, imem_rdata, redirect, redirect_target, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4, fetch_misaligned,
        output imem_ack, imem_rdata, redirect, redirect_target, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request/ack, valid/ready hand-off to decode, redirects.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect target raises a sticky flag and halts.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {FETCH, HOLD, DROP, HALT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_addr;
    logic                  halt_pend;
    logic                  misaligned_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0] instr_pc_q;
    logic [ADDR_WIDTH-1:0] instr_pc_plus4_q;
    logic [ADDR_WIDTH-1:0] tgt;
    logic                  tgt_bad;

    function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] a);
        return a + ADDR_WIDTH'(4);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(3);
    endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt     = bus.redirect_target;
    assign tgt_bad = |bus.redirect_target[1:0];
`else
    assign tgt     = word_align(bus.redirect_target);
    assign tgt_bad = 1'b0;
`endif

    // The request stays up through DROP so the memory sees a stable, never-withdrawn transaction.
    assign bus.imem_req         = !rst && (state == FETCH || state == DROP);
    assign bus.imem_addr        = (state == DROP) ? inflight_addr : pc;
    assign bus.instr_valid      = valid_q;
    assign bus.instr            = instr_q;
    assign bus.instr_pc         = instr_pc_q;
    assign bus.instr_pc_plus4   = instr_pc_plus4_q;
    assign bus.fetch_misaligned = misaligned_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= FETCH;
            pc               <= RESET_PC;
            halt_pend        <= 1'b0;
            misaligned_q     <= 1'b0;
            valid_q          <= 1'b0;
            instr_q          <= '0;
            instr_pc_q       <= '0;
            instr_pc_plus4_q <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.redirect) begin
                        if (tgt_bad) begin
                            misaligned_q <= 1'b1;
                            if (bus.imem_ack) begin
                                state <= HALT;
                            end else begin
                                state         <= DROP;
                                inflight_addr <= pc;
                                halt_pend     <= 1'b1;
                            end
                        end else begin
                            pc <= tgt;
                            if (!bus.imem_ack) begin
                                state         <= DROP;
                                inflight_addr <= pc;
                            end
                        end
                    end else if (bus.imem_ack) begin
                        instr_q          <= bus.imem_rdata;
                        instr_pc_q       <= pc;
                        instr_pc_plus4_q <= pc_inc(pc);
                        valid_q          <= 1'b1;
                        pc               <= pc_inc(pc);
                        state            <= HOLD;
                    end
                end
                HOLD: begin
                    // A same-cycle ready still completes the hand-off; the redirect then only steers pc.
                    if (bus.redirect) begin
                        valid_q <= 1'b0;
                        if (tgt_bad) begin
                            misaligned_q <= 1'b1;
                            state        <= HALT;
                        end else begin
                            pc    <= tgt;
                            state <= FETCH;
                        end
                    end else if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        state   <= FETCH;
                    end
                end
                DROP: begin
                    if (bus.redirect) begin
                        if (tgt_bad) begin
                            misaligned_q <= 1'b1;
                            halt_pend    <= 1'b1;
                        end else begin
                            pc <= tgt;
                        end
                    end
                    if (bus.imem_ack) begin
                        state <= (halt_pend || (bus.redirect && tgt_bad)) ? HALT : FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory responder with random latency, and a scoreboard
// that predicts the PC stream decode must see from the fetch/redirect rules.
module tb_fetch_unit;
    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam logic [31:0] RST_PC = 32'h0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory contents: a bijective function of the address, so every word identifies its PC.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // reference model state
    logic [31:0] exp_pc;
    bit          halted;
    int          delivered;
    logic [31:0] last_dpc, last_dp4;

    // memory responder state
    bit          pending;
    logic [31:0] req_addr;
    int          lat;
    int          force_lat = -1;
    int          new_req_cnt = 0;
    logic [31:0] new_req_addr;

    // hold-stability tracking
    bit          last_hold;
    logic [31:0] last_instr, last_ipc;

    task automatic tick(input bit rdy, input bit rd, input logic [31:0] tgt);
        @(negedge clk);
        bus.instr_ready     = rdy;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        if (rst) begin
            pending      = 0;
            halted       = 0;
            last_hold    = 0;
            exp_pc       = RST_PC;
            bus.imem_ack = 1'b0;
            chk_eq("rst_valid", bus.instr_valid, 1'b0);
            chk_eq("rst_req", bus.imem_req, 1'b0);
        end else begin
            if (bus.imem_ack) pending = 0;
            if (last_hold) begin
                chk_eq("hold_valid", bus.instr_valid, 1'b1);
                chk_eq("hold_instr", bus.instr, last_instr);
                chk_eq("hold_pc", bus.instr_pc, last_ipc);
            end
            if (pending) begin
                chk_eq("req_held", bus.imem_req, 1'b1);
                chk_eq("req_addr_stable", bus.imem_addr, req_addr);
            end else if (bus.imem_req) begin
                pending      = 1;
                req_addr     = bus.imem_addr;
                new_req_cnt++;
                new_req_addr = bus.imem_addr;
                lat          = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            end
            if (pending && lat == 0) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = memf(req_addr);
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
                if (pending) lat--;
            end
            if (bus.instr_valid) chk_eq("no_req_in_hold", bus.imem_req, 1'b0);
            if (halted) chk_eq("halt_valid", bus.instr_valid, 1'b0);
            if (bus.instr_valid && rdy) begin
                chk_eq("instr_pc", bus.instr_pc, exp_pc);
                chk_eq("instr", bus.instr, memf(exp_pc));
                chk_eq("instr_pc_plus4", bus.instr_pc_plus4, exp_pc + 32'd4);
                last_dpc = bus.instr_pc;
                last_dp4 = bus.instr_pc_plus4;
                delivered++;
                exp_pc = exp_pc + 32'd4;
            end
            if (rd && !halted) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (tgt[1:0] != 2'b00) halted = 1;
                else exp_pc = tgt;
`else
                exp_pc = {tgt[31:2], 2'b00};
`endif
            end
            last_hold  = bus.instr_valid && !rdy && !rd;
            last_instr = bus.instr;
            last_ipc   = bus.instr_pc;
        end
    endtask

    task automatic wait_new_req(input string tag);
        int c = new_req_cnt;
        for (int i = 0; i < 60 && new_req_cnt == c; i++) tick(1'b1, 1'b0, 32'h0);
        chk_eq(tag, new_req_cnt, c + 1);
    endtask

    task automatic wait_deliver(input string tag);
        int d = delivered;
        for (int i = 0; i < 60 && delivered == d; i++) tick(1'b1, 1'b0, 32'h0);
        chk_eq(tag, delivered, d + 1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60 && !bus.instr_valid; i++) tick(1'b0, 1'b0, 32'h0);
        chk_eq(tag, bus.instr_valid, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        logic [31:0] t;
        rst                 = 1'b1;
        bus.imem_ack        = 1'b0;
        bus.imem_rdata      = '0;
        bus.redirect        = 1'b0;
        bus.redirect_target = '0;
        bus.instr_ready     = 1'b0;
        delivered           = 0;
        pending             = 0;
        last_hold           = 0;
        exp_pc              = RST_PC;

        // reset state
        repeat (3) tick(1'b1, 1'b0, 32'h0);
        chk_eq("rst_instr", bus.instr, 32'h0);
        chk_eq("rst_instr_pc", bus.instr_pc, 32'h0);
        chk_eq("rst_pc_plus4", bus.instr_pc_plus4, 32'h0);
        chk_eq("rst_misaligned", bus.fetch_misaligned, 1'b0);
        rst = 1'b0;

        // sequential fetch, 1-cycle memory, decode always ready
        force_lat = 1;
        for (int i = 0; i < 60 && delivered < 3; i++) tick(1'b1, 1'b0, 32'h0);
        chk_eq("t1_count", delivered, 3);
        chk_eq("t1_last_pc", last_dpc, 32'h8);
        chk_eq("t1_last_pc4", last_dp4, 32'hC);

        // decode stalls five cycles
        wait_valid("t2_valid");
        repeat (5) tick(1'b0, 1'b0, 32'h0);
        chk_eq("t2_pc", bus.instr_pc, 32'hC);
        chk_eq("t2_req_off", bus.imem_req, 1'b0);
        tick(1'b1, 1'b0, 32'h0);

        // redirect while a slow request is outstanding
        force_lat = 3;
        wait_new_req("t3_req");
        tick(1'b1, 1'b1, 32'h100);
        wait_new_req("t3_req2");
        chk_eq("t3_addr", new_req_addr, 32'h100);
        wait_deliver("t3_deliver");
        chk_eq("t3_pc", last_dpc, 32'h100);

        // two redirects during DROP: latest wins
        wait_new_req("t4_req");
        tick(1'b1, 1'b1, 32'h40);
        tick(1'b1, 1'b1, 32'h80);
        wait_new_req("t4_req2");
        chk_eq("t4_addr", new_req_addr, 32'h80);
        // redirect together with ready in HOLD
        wait_valid("t4_valid");
        d0 = delivered;
        tick(1'b1, 1'b1, 32'h200);
        chk_eq("t4_handshake", delivered, d0 + 1);
        wait_deliver("t4_deliver");
        chk_eq("t4_pc", last_dpc, 32'h200);

        // wrap at the top of the address space
        force_lat = 0;
        tick(1'b1, 1'b1, 32'hFFFF_FFFC);
        wait_deliver("t5_deliver");
        chk_eq("t5_pc", last_dpc, 32'hFFFF_FFFC);
        chk_eq("t5_pc4", last_dp4, 32'h0);
        wait_new_req("t5_req");
        chk_eq("t5_addr", new_req_addr, 32'h0);

        // misaligned redirect target
        force_lat = 2;
        tick(1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (20) tick(1'b1, 1'b0, 32'h0);
        chk_eq("t6_flag", bus.fetch_misaligned, 1'b1);
        chk_eq("t6_req", bus.imem_req, 1'b0);
        tick(1'b1, 1'b1, 32'h300);
        repeat (5) tick(1'b1, 1'b0, 32'h0);
        chk_eq("t6_req_after", bus.imem_req, 1'b0);
        chk_eq("t6_flag_sticky", bus.fetch_misaligned, 1'b1);
`else
        wait_new_req("t6_req");
        chk_eq("t6_addr", new_req_addr, 32'h100);
        wait_deliver("t6_deliver");
        chk_eq("t6_pc", last_dpc, 32'h100);
        chk_eq("t6_flag", bus.fetch_misaligned, 1'b0);
`endif

        // randomized traffic with one mid-run reset
        rst = 1'b1;
        repeat (2) tick(1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        chk_eq("rr_flag", bus.fetch_misaligned, 1'b0);
        force_lat = -1;
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            t = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            t[1:0] = 2'b00;
`endif
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, t);
            if (i == 1500) rst = 1'b1;
            if (i == 1502) rst = 1'b0;
        end
        chk_eq("rand_progress", delivered > d0 + 200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
